// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Imported by pipe_div_seq and pipe_stall_ctrl.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {StRun, StDiv} div_state_e;

    localparam int unsigned StageF = 0;
    localparam int unsigned StageD = 1;
    localparam int unsigned StageE = 2;
    localparam int unsigned StageM = 3;
    localparam int unsigned StageW = 4;

    localparam int unsigned RegW = 5;

    // r0 is hardwired to zero, so a load into it never creates a hazard.
    function automatic logic load_use(input logic            mem_read,
                                      input logic [RegW-1:0] ex_rt,
                                      input logic [RegW-1:0] rs,
                                      input logic [RegW-1:0] rt);
        return mem_read && (ex_rt != '0) && ((ex_rt == rs) || (ex_rt == rt));
    endfunction

endpackage

// File: rtl/pipe_div_seq.sv
// Divider sequencer: RUN/DIV state, latency down-counter, start/abort pulses
// and the done condition used by pipe_stall_ctrl.
module pipe_div_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic div_req,
    input  logic mem_stall,
    input  logic m_exc,
    output logic in_div,
    output logic cnt_zero,
    output logic div_start,
    output logic div_abort,
    output logic div_done
);

    localparam logic [7:0] CntInit = 8'(DIV_CYCLES - 1);

    div_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (div_start) begin
                    state_d = StDiv;
                    cnt_d   = CntInit;
                end
            end
            StDiv: begin
                // The divider runs on its own clock budget; memory stalls do not pause it.
                if (cnt_q != '0) cnt_d = cnt_q - 8'd1;
                if (div_abort || div_done) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        in_div    = (state_q == StDiv);
        cnt_zero  = (cnt_q == '0);
        div_start = !in_div && div_req && !mem_stall && !m_exc;
        div_abort = in_div && m_exc && !mem_stall;
        div_done  = in_div && !m_exc && !mem_stall && cnt_zero;
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the F/D/E/M/W pipeline.
// Define PIPE_STALL_CTRL_PERF_EN to add the stall/divide/flush performance counters.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_stall,
    input  logic            d_stall,
    input  logic            ex_mem_read,
    input  logic [RegW-1:0] ex_rt,
    input  logic [RegW-1:0] id_rs,
    input  logic [RegW-1:0] id_rt,
    input  logic            ex_div_req,
    input  logic            m_exc,
    output logic            en_f,
    output logic            en_d,
    output logic            en_e,
    output logic            en_m,
    output logic            en_w,
    output logic            clr_d,
    output logic            clr_e,
    output logic            clr_m,
    output logic            clr_w,
    output logic            div_start,
    output logic            div_abort,
    output logic            exc_redirect
`ifdef PIPE_STALL_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_stall_cyc,
    output logic [31:0]     perf_div_cyc,
    output logic [31:0]     perf_flush_cnt
`endif
);

    logic mem_stall, lu;
    logic in_div, cnt_zero, seq_start, seq_abort, seq_done;
    logic [StageW:StageF] en;
    logic [StageW:StageD] clr;

    assign mem_stall = i_stall | d_stall;
    assign lu        = load_use(ex_mem_read, ex_rt, id_rs, id_rt);

    pipe_div_seq #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_seq (
        .clk       (clk),
        .rst       (rst),
        .div_req   (ex_div_req),
        .mem_stall (mem_stall),
        .m_exc     (m_exc),
        .in_div    (in_div),
        .cnt_zero  (cnt_zero),
        .div_start (seq_start),
        .div_abort (seq_abort),
        .div_done  (seq_done)
    );

    always_comb begin
        en           = '0;
        clr          = '0;
        div_start    = 1'b0;
        div_abort    = 1'b0;
        exc_redirect = 1'b0;
        if (rst) begin
            // Hold everything while in reset.
        end else if (in_div ? seq_abort : (!mem_stall && m_exc)) begin
            en           = '1;
            clr          = '1;
            exc_redirect = 1'b1;
            div_abort    = seq_abort;
        end else if (mem_stall) begin
            // Freeze the whole pipe; a pending exception waits for the bus.
        end else if (seq_start || (in_div && !cnt_zero)) begin
            // Divide in E: keep F/D/E, let M take a bubble, drain W.
            div_start   = seq_start;
            en[StageM]  = 1'b1;
            en[StageW]  = 1'b1;
            clr[StageM] = 1'b1;
        end else if (!in_div && lu) begin
            en[StageE]  = 1'b1;
            en[StageM]  = 1'b1;
            en[StageW]  = 1'b1;
            clr[StageE] = 1'b1;
        end else begin
            en = '1;
        end
    end

    assign en_f  = en[StageF];
    assign en_d  = en[StageD];
    assign en_e  = en[StageE];
    assign en_m  = en[StageM];
    assign en_w  = en[StageW];
    assign clr_d = clr[StageD];
    assign clr_e = clr[StageE];
    assign clr_m = clr[StageM];
    assign clr_w = clr[StageW];

`ifdef PIPE_STALL_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cyc <= '0;
            perf_div_cyc   <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (!en_f)        perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (in_div)       perf_div_cyc   <= perf_div_cyc + 32'd1;
            if (exc_redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    logic unused_done;
    assign unused_done = seq_done;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the stall/flush rules.
module tb_pipe_stall_ctrl;

    localparam int unsigned DC = 4;

    // Packed view: {en_f,en_d,en_e,en_m,en_w, clr_d,clr_e,clr_m,clr_w, start,abort,redirect}
    localparam logic [11:0] VZero  = 12'b00000_0000_000;
    localparam logic [11:0] VRun   = 12'b11111_0000_000;
    localparam logic [11:0] VFlush = 12'b11111_1111_001;
    localparam logic [11:0] VAbort = 12'b11111_1111_011;
    localparam logic [11:0] VStart = 12'b00011_0010_100;
    localparam logic [11:0] VHold  = 12'b00011_0010_000;
    localparam logic [11:0] VLu    = 12'b00111_0100_000;

    logic       clk = 1'b0;
    logic       rst, i_stall, d_stall, ex_mem_read, ex_div_req, m_exc;
    logic [4:0] ex_rt, id_rs, id_rt;
    logic       en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m, clr_w;
    logic       div_start, div_abort, exc_redirect;
`ifdef PIPE_STALL_CTRL_PERF_EN
    logic [31:0] perf_stall_cyc, perf_div_cyc, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .DIV_CYCLES (DC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_stall      (i_stall),
        .d_stall      (d_stall),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_div_req   (ex_div_req),
        .m_exc        (m_exc),
        .en_f         (en_f),
        .en_d         (en_d),
        .en_e         (en_e),
        .en_m         (en_m),
        .en_w         (en_w),
        .clr_d        (clr_d),
        .clr_e        (clr_e),
        .clr_m        (clr_m),
        .clr_w        (clr_w),
        .div_start    (div_start),
        .div_abort    (div_abort),
        .exc_redirect (exc_redirect)
`ifdef PIPE_STALL_CTRL_PERF_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_div_cyc   (perf_div_cyc),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    int checks = 0;
    int passes = 0;

    // Model: whether a divide occupies E, and how many cycles since its start cycle.
    bit          m_div = 1'b0;
    int          m_age = 0;
    bit          nx_div;
    int          nx_age;
    logic [31:0] m_stall = '0, m_divc = '0, m_flush = '0;

    task automatic model(output logic [11:0] e);
        bit ms, lu;
        ms     = i_stall || d_stall;
        lu     = ex_mem_read && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
        nx_div = m_div;
        nx_age = m_age + 1;
        if (rst) begin
            e      = VZero;
            nx_div = 1'b0;
        end else if (!m_div) begin
            if (ms)              e = VZero;
            else if (m_exc)      e = VFlush;
            else if (ex_div_req) begin
                e      = VStart;
                nx_div = 1'b1;
                nx_age = 1;
            end
            else if (lu)         e = VLu;
            else                 e = VRun;
        end else begin
            if (m_exc && !ms) begin
                e      = VAbort;
                nx_div = 1'b0;
            end
            else if (ms)         e = VZero;
            else if (m_age < DC) e = VHold;
            else begin
                e      = VRun;
                nx_div = 1'b0;
            end
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input logic r, input logic i, input logic d, input logic exc,
                        input logic req, input logic mr, input logic [4:0] ert,
                        input logic [4:0] rs, input logic [4:0] rt, input string tag);
        logic [11:0] exp, obs;
        @(negedge clk);
        rst = r; i_stall = i; d_stall = d; m_exc = exc; ex_div_req = req;
        ex_mem_read = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
        #1;
        model(exp);
        obs = {en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m, clr_w,
               div_start, div_abort, exc_redirect};
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
`ifdef PIPE_STALL_CTRL_PERF_EN
        check32({tag, "_perf_stall"}, perf_stall_cyc, r ? 32'd0 : m_stall);
        check32({tag, "_perf_div"},   perf_div_cyc,   r ? 32'd0 : m_divc);
        check32({tag, "_perf_flush"}, perf_flush_cnt, r ? 32'd0 : m_flush);
`endif
        if (r) begin
            m_stall = '0; m_divc = '0; m_flush = '0;
        end else begin
            if (!exp[11]) m_stall++;
            if (m_div)    m_divc++;
            if (exp[0])   m_flush++;
        end
        m_div = nx_div;
        m_age = nx_age;
    endtask

    initial begin
        // Reset, including busy inputs that must be ignored.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        step(1, 1, 0, 1, 1, 1, 5, 5, 5, "reset_inputs");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");

        // Load-use hazards.
        step(0, 0, 0, 0, 0, 1, 5, 5, 0, "lu_rs");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "after_lu");
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, "lu_r0");
        step(0, 0, 0, 0, 0, 1, 7, 1, 7, "lu_rt");
        step(0, 0, 0, 0, 0, 1, 7, 1, 2, "lu_miss");

        // Plain divide: start, DC-1 holds, completion.
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, "div_start");
        for (int k = 0; k < DC - 1; k++) step(0, 0, 0, 0, 1, 0, 0, 0, 0, "div_hold");
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, "div_done");
        step(0, 0, 0, 0, 0, 1, 3, 3, 0, "div_after");

        // d_stall for 3 cycles at cnt == 0 stretches the completion.
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, "div2_start");
        for (int k = 0; k < DC - 1; k++) step(0, 0, 0, 0, 1, 0, 0, 0, 0, "div2_hold");
        for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 1, 0, 0, 0, 0, "div2_dstall");
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, "div2_done");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "div2_after");

        // Exception in the second DIV cycle aborts the divide.
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, "div3_start");
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, "div3_hold");
        step(0, 0, 0, 1, 1, 0, 0, 0, 0, "div3_abort");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "after_abort");

        // Exception deferred behind i_stall.
        step(0, 1, 0, 1, 0, 0, 0, 0, 0, "exc_istall");
        step(0, 1, 0, 1, 0, 0, 0, 0, 0, "exc_istall");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, "exc_flush");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "after_flush");

        // Reset mid-divide (cnt == 2), then a fresh divide.
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, "div4_start");
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, "div4_hold");
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, "rst_mid_div");
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, "post_rst_start");
        for (int k = 0; k < DC - 1; k++) step(0, 0, 0, 0, 1, 0, 0, 0, 0, "div5_hold");
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, "div5_done");

        // Random traffic with small register numbers to provoke hazards.
        for (int n = 0; n < 500; n++) begin
            logic r, i, d, exc, req, mr;
            logic [4:0] ert, rs, rt;
            r   = ($urandom_range(0, 99) == 0);
            i   = ($urandom_range(0, 99) < 15);
            d   = ($urandom_range(0, 99) < 15);
            exc = ($urandom_range(0, 99) < 6);
            req = ($urandom_range(0, 99) < 30);
            mr  = ($urandom_range(0, 99) < 40);
            ert = 5'($urandom_range(0, 3));
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            step(r, i, d, exc, req, mr, ert, rs, rt, "random");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush controller for the 5-stage CPU pipeline (F, D, E, M, W). Each cycle it drives the enable and clear inputs of every inter-stage register. Its inputs are the AXI fetch/data busy flags, load-use hazard detection, M-stage exceptions, and a fixed-latency multi-cycle divider in E. The divider is sequenced by an internal cycle counter so the rest of the pipeline never sees a partially computed quotient.

## Interface
- DIV_CYCLES, 32: divider latency in cycles after the start cycle; legal range 1..255.
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- i_stall  in  1  fetch AXI transaction outstanding.
- d_stall  in  1  data AXI transaction outstanding.
- ex_mem_read  in  1  E-stage instruction is a load.
- ex_rt  in  5  load destination register in E.
- id_rs, id_rt  in  5 each  D-stage source registers.
- ex_div_req  in  1  E-stage instruction is div/divu.
- m_exc  in  1  M-stage instruction raised an exception or eret.
- en_f, en_d, en_e, en_m, en_w  out  1 each  enables for the PC, D, E, M and W registers.
- clr_d, clr_e, clr_m, clr_w  out  1 each  synchronous clears (bubble) for the D, E, M and W registers.
- div_start  out  1  one-cycle pulse that launches the divider.
- div_abort  out  1  one-cycle pulse that cancels a running divide.
- exc_redirect  out  1  selects the exception/eret vector as the next PC.

## Operation
- Definitions:
  - mem_stall = i_stall | d_stall.
  - lu = ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
- FSM has two states, RUN and DIV. cnt is an 8-bit down-counter.
- RUN priority (first match wins):
  1. mem_stall: all en = 0, all clr = 0. This includes cycles with m_exc; the exception is deferred until mem_stall drops.
  2. m_exc: all en = 1; clr_d, clr_e, clr_m, clr_w = 1; exc_redirect = 1.
  3. ex_div_req: div_start = 1; en_f, en_d, en_e = 0; en_m = clr_m = 1; en_w = 1. Next state DIV, cnt = DIV_CYCLES-1.
  4. lu: en_f, en_d = 0; clr_e = 1; en_e, en_m, en_w = 1.
  5. Otherwise: all en = 1, all clr = 0.
- DIV state:
  - cnt decrements every cycle while cnt > 0, regardless of mem_stall.
  - m_exc & !mem_stall: div_abort = 1, perform the flush from RUN item 2, next state RUN.
  - mem_stall: all en = 0, all clr = 0.
  - cnt > 0: en_f, en_d, en_e = 0; en_m = clr_m = 1; en_w = 1.
  - cnt == 0: all en = 1, all clr = 0, next state RUN. This is the completion cycle, in which the E instruction advances.
- Clear outputs are only meaningful together with the matching en; clr has priority inside the register.

## Timing
- All outputs are combinational from state and inputs. state and cnt are registered.
- While rst is high: state = RUN, cnt = 0; all en = 0, all clr = 0; div_start = div_abort = exc_redirect = 0.
- Rst asserted mid-divide: the controller returns to RUN with no div_abort pulse. The divider shares the same reset.
- Divide occupancy of E is DIV_CYCLES+1 cycles (start cycle plus DIV_CYCLES) when there is no mem_stall. Each mem_stall cycle at cnt == 0 extends occupancy by one.
- div_start is never asserted in DIV state. The next ex_div_req is honoured at the earliest in the cycle after completion.
- A load-use stall costs exactly one bubble. A flush costs one cycle of outputs.

## Configuration
- PIPE_STALL_CTRL_PERF_EN defined:
  - Adds outputs perf_stall_cyc, perf_div_cyc and perf_flush_cnt, each 32-bit, reset 0, wrapping.
  - perf_stall_cyc counts cycles with en_f = 0.
  - perf_div_cyc counts cycles spent in DIV.
  - perf_flush_cnt counts cycles with exc_redirect = 1.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, DIV);
  - the stage index constants (F, D, E, M, W);
  - the register-number width constant (5).
- One sub-module, pipe_div_seq, holds the state register, cnt, the start/abort logic and the done condition. Priority muxing of enables and clears stays in the top level.

## Test plan
- Load r5 in E, D reads r5 as rs -> exactly one cycle of en_f = en_d = 0 and clr_e = 1; no stall when ex_rt = 0.
- ex_div_req with DIV_CYCLES = 4, no stalls -> div_start for 1 cycle, en_e = 0 for 4 cycles, completion on the 5th cycle, then RUN.
- d_stall held for 3 cycles while cnt == 0 -> all en = 0 for those 3 cycles; completion occurs on the first cycle with d_stall = 0.
- m_exc in the 2nd DIV cycle -> div_abort = 1, exc_redirect = 1, clr_d, clr_e, clr_m, clr_w = 1, state back to RUN.
- m_exc with i_stall high for 2 cycles -> all en = 0 and no redirect for 2 cycles; the flush fires on the 3rd cycle.
- rst pulse mid-divide (cnt = 2) -> all outputs 0 during reset; after release state is RUN and a new ex_div_req produces div_start.
